alu_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_shifter.sv | 30 +++
 rtl/alu_unit.sv | 79 +++++++
 tb/tb_alu_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU: control-code width and operation encodings.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_LUI = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } aluOp_t;

endpackage

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter; left shifts reuse the right-shift stages on a bit-reversed operand.
module alu_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int SH_W       = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [SH_W-1:0]       amount,
  input  logic                  dirLeft,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] stage;

  always_comb begin
    stage = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      stage[i] = dirLeft ? a[DATA_WIDTH-1-i] : a[i];
    end
    for (int unsigned s = 0; s < SH_W; s++) begin
      if (amount[s]) begin
        stage = stage >> (1 << s);
      end
    end
    result = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      result[i] = dirLeft ? stage[DATA_WIDTH-1-i] : stage[i];
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Combinational RV32I ALU with zero flag; define ALU_OUT_REG_EN to add a registered
// copy of result and flag on aluResultQ/zeroQ (otherwise those outputs are tied to 0).
module alu_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  input  logic [ALU_CTRL_W-1:0] aluControl,
  output logic [DATA_WIDTH-1:0] aluResult,
  output logic                  zero,
  output logic [DATA_WIDTH-1:0] aluResultQ,
  output logic                  zeroQ
);

  localparam int SH = $clog2(DATA_WIDTH);

  aluOp_t                op;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH-1:0] shiftResult;
  logic                  lessThan;

  assign op   = aluOp_t'(aluControl);
  assign sum  = srcA + srcB;
  assign diff = srcA - srcB;

  // Differing signs decide directly; equal signs cannot overflow, so the difference sign is exact.
  assign lessThan = (srcA[DATA_WIDTH-1] != srcB[DATA_WIDTH-1]) ? srcA[DATA_WIDTH-1]
                                                                : diff[DATA_WIDTH-1];

  alu_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .SH_W      (SH)
  ) uShifter (
    .a      (srcA),
    .amount (srcB[SH-1:0]),
    .dirLeft(op == ALU_SLL),
    .result (shiftResult)
  );

  always_comb begin
    aluResult = '0;
    case (op)
      ALU_ADD: aluResult = sum;
      ALU_SUB: aluResult = diff;
      ALU_AND: aluResult = srcA & srcB;
      ALU_OR:  aluResult = srcA | srcB;
      ALU_LUI: aluResult = srcB;
      ALU_SLT: aluResult = {{(DATA_WIDTH-1){1'b0}}, lessThan};
      ALU_SLL: aluResult = shiftResult;
      ALU_SRL: aluResult = shiftResult;
      default: aluResult = '0;
    endcase
  end

  assign zero = (aluResult == '0);

`ifdef ALU_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluResultQ <= '0;
      zeroQ      <= 1'b0;
    end else begin
      aluResultQ <= aluResult;
      zeroQ      <= zero;
    end
  end
`else
  logic unusedClkRst;
  assign unusedClkRst = clk & rst_n;
  assign aluResultQ   = '0;
  assign zeroQ        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, randomized model comparison,
// and registered-output sequences (or tie-off checks when ALU_OUT_REG_EN is undefined).
module tb_alu_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   ctrl;
    logic [W-1:0] expResult;
    logic         expZero;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic [2:0]   aluControl;
  logic [W-1:0] aluResult;
  logic         zero;
  logic [W-1:0] aluResultQ;
  logic         zeroQ;

  int checks   = 0;
  int failures = 0;

  alu_unit #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .srcA      (srcA),
    .srcB      (srcB),
    .aluControl(aluControl),
    .aluResult (aluResult),
    .zero      (zero),
    .aluResultQ(aluResultQ),
    .zeroQ     (zeroQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model straight from the operation table.
  function automatic logic [W-1:0] refAlu(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] c);
    longint unsigned amt;
    amt = longint'(b % W);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return b;
      3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd6: return a << amt;
      default: return a >> amt;
    endcase
  endfunction

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    srcA = a;
    srcB = b;
    aluControl = c;
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] a, b, expR;
    logic [2:0]   c;

    rst_n = 1'b0;
    srcA = '0;
    srcB = '0;
    aluControl = 3'd0;

    vecs.push_back('{32'd15,         32'd10,         3'd0, 32'd25,         1'b0});
    vecs.push_back('{32'hFFFFFFFF,   32'd1,          3'd0, 32'd0,          1'b1});
    vecs.push_back('{32'd20,         32'd5,          3'd1, 32'd15,         1'b0});
    vecs.push_back('{32'd5,          32'd5,          3'd1, 32'd0,          1'b1});
    vecs.push_back('{32'hA5A5A5A5,   32'h5A5A5A5A,   3'd2, 32'h00000000,   1'b1});
    vecs.push_back('{32'hA5A5A5A5,   32'h5A5A5A5A,   3'd3, 32'hFFFFFFFF,   1'b0});
    vecs.push_back('{32'h12345678,   32'h87654321,   3'd4, 32'h87654321,   1'b0});
    vecs.push_back('{32'hFFFFFFFB,   32'd10,         3'd5, 32'd1,          1'b0});
    vecs.push_back('{32'd10,         32'hFFFFFFFB,   3'd5, 32'd0,          1'b1});
    vecs.push_back('{32'h80000000,   32'h7FFFFFFF,   3'd5, 32'd1,          1'b0});
    vecs.push_back('{32'h7FFFFFFF,   32'h80000000,   3'd5, 32'd0,          1'b1});
    vecs.push_back('{32'd1,          32'd4,          3'd6, 32'd16,         1'b0});
    vecs.push_back('{32'd16,         32'd2,          3'd7, 32'd4,          1'b0});
    vecs.push_back('{32'h80000000,   32'd31,         3'd7, 32'd1,          1'b0});
    vecs.push_back('{32'd1,          32'd33,         3'd6, 32'd2,          1'b0});
    vecs.push_back('{32'hDEADBEEF,   32'd0,          3'd6, 32'hDEADBEEF,   1'b0});
    vecs.push_back('{32'hDEADBEEF,   32'd32,         3'd7, 32'hDEADBEEF,   1'b0});
    vecs.push_back('{32'hF0000000,   32'd4,          3'd7, 32'h0F000000,   1'b0});

    // Reset state of the registered copy (always 0, either build).
    #2;
    check("reset_resultQ", aluResultQ, '0);
    check("reset_zeroQ", {31'd0, zeroQ}, '0);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].ctrl);
      check($sformatf("vec%0d_result", i), aluResult, vecs[i].expResult);
      check($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].expZero});
    end

    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = b & 32'h3F;
        default: ;
      endcase
      c = 3'($urandom_range(0, 7));
      apply(a, b, c);
      expR = refAlu(a, b, c);
      check($sformatf("rand%0d_op%0d_result", n, c), aluResult, expR);
      check($sformatf("rand%0d_op%0d_zero", n, c), {31'd0, zero}, {31'd0, expR == '0});
    end

`ifdef ALU_OUT_REG_EN
    @(negedge clk);
    apply(32'd15, 32'd10, 3'd0);
    @(posedge clk); #1;
    check("held_in_reset_resultQ", aluResultQ, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_capture_resultQ", aluResultQ, 32'd25);
    check("first_capture_zeroQ", {31'd0, zeroQ}, '0);
    @(negedge clk);
    apply(32'hFFFFFFFF, 32'd1, 3'd0);
    check("pre_edge_resultQ", aluResultQ, 32'd25);
    @(posedge clk); #1;
    check("capture2_resultQ", aluResultQ, '0);
    check("capture2_zeroQ", {31'd0, zeroQ}, 32'd1);
    @(negedge clk);
    apply(32'd20, 32'd5, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_resultQ", aluResultQ, '0);
    check("async_reset_zeroQ", {31'd0, zeroQ}, '0);
    check("comb_during_reset", aluResult, 32'd15);
    @(posedge clk); #1;
    check("reset_holds_resultQ", aluResultQ, '0);
`else
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      apply(32'd15 + 32'(n), 32'd10, 3'd0);
      @(posedge clk); #1;
      check($sformatf("tied_resultQ%0d", n), aluResultQ, '0);
      check($sformatf("tied_zeroQ%0d", n), {31'd0, zeroQ}, '0);
      check($sformatf("comb_with_clk%0d", n), aluResult, 32'd25 + 32'(n));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
